// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic pipeline register: occupancy states and
// the bubble (nop) fill value used whenever a slot holds no word.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } pipe_state_e;

  // Replicate across any word width to build the all-zero bubble word.
  localparam logic BUBBLE_FILL = 1'b0;

endpackage

// File: rtl/pipe_reg_elastic_if.sv
// Upstream/downstream handshake bundle for one elastic pipeline stage.
interface pipe_reg_elastic_if #(
  parameter int NF    = 5,
  parameter int W     = 32,
  parameter int CNT_W = 16
);
  logic            in_valid;
  logic            in_ready;
  logic [NF*W-1:0] in_data;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [NF*W-1:0] out_data;
  logic [CNT_W-1:0] stall_cnt;

  // The stage itself.
  modport slave (
    input  in_valid, in_data, flush, out_ready,
    output in_ready, out_valid, out_data, stall_cnt
  );

  // Whatever surrounds the stage (upstream producer plus downstream consumer).
  modport master (
    output in_valid, in_data, flush, out_ready,
    input  in_ready, out_valid, out_data, stall_cnt
  );
endinterface

// File: rtl/pipe_slot.sv
// One word of pipeline storage: per-field registers with clear, load and hold.
module pipe_slot #(
  parameter int NF = 5,
  parameter int W  = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load_i,
  input  logic            clear_i,
  input  logic [NF*W-1:0] d_i,
  output logic [NF*W-1:0] q_o
);
  import pipe_pkg::*;

  genvar gi;
  generate
    for (gi = 0; gi < NF; gi++) begin : g_field
      logic [W-1:0] field_q;

      // Clear wins over load so a squash can never leave a stale field behind.
      always_ff @(posedge clk) begin
        if (reset || clear_i) begin
          field_q <= {W{BUBBLE_FILL}};
        end else if (load_i) begin
          field_q <= d_i[gi*W +: W];
        end
      end

      assign q_o[gi*W +: W] = field_q;
    end
  endgenerate
endmodule

// File: rtl/pipe_reg_elastic.sv
// Two-entry elastic pipeline register (main + skid) with flush and a saturating
// count of downstream back-pressure cycles.
module pipe_reg_elastic #(
  parameter int NF    = 5,
  parameter int W     = 32,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  pipe_reg_elastic_if.slave  bus
);
  import pipe_pkg::*;

  localparam int DW = NF * W;

  pipe_state_e      state_q, state_d;
  logic [DW-1:0]    main_q, skid_q, main_d;
  logic             main_load, main_clr, main_from_skid;
  logic             skid_load, skid_clr;
  logic             in_fire, out_fire;
  logic [CNT_W-1:0] stall_q;

  // Handshake outputs depend on registered state only, never on the
  // incoming valid/ready, so stages can be chained without comb loops.
  assign bus.in_ready  = (state_q != FULL);
  assign bus.out_valid = (state_q != EMPTY);
  assign bus.out_data  = main_q;
  assign bus.stall_cnt = stall_q;

  assign in_fire  = bus.in_valid  & bus.in_ready;
  assign out_fire = bus.out_valid & bus.out_ready;

  always_comb begin
    state_d        = state_q;
    main_load      = 1'b0;
    main_clr       = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    skid_clr       = 1'b0;
    if (bus.flush) begin
      state_d  = EMPTY;
      main_clr = 1'b1;
      skid_clr = 1'b1;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_fire) begin
            state_d   = HALF;
            main_load = 1'b1;
          end
        end
        HALF: begin
          if (in_fire && out_fire) begin
            main_load = 1'b1;
          end else if (in_fire) begin
            state_d   = FULL;
            skid_load = 1'b1;
          end else if (out_fire) begin
            state_d  = EMPTY;
            main_clr = 1'b1;
          end
        end
        FULL: begin
          if (out_fire) begin
            state_d        = HALF;
            main_load      = 1'b1;
            main_from_skid = 1'b1;
            skid_clr       = 1'b1;
          end
        end
        default: begin
          state_d  = EMPTY;
          main_clr = 1'b1;
          skid_clr = 1'b1;
        end
      endcase
    end
  end

  assign main_d = main_from_skid ? skid_q : bus.in_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  pipe_slot #(.NF(NF), .W(W)) u_main (
    .clk     (clk),
    .reset   (reset),
    .load_i  (main_load),
    .clear_i (main_clr),
    .d_i     (main_d),
    .q_o     (main_q)
  );

  pipe_slot #(.NF(NF), .W(W)) u_skid (
    .clk     (clk),
    .reset   (reset),
    .load_i  (skid_load),
    .clear_i (skid_clr),
    .d_i     (bus.in_data),
    .q_o     (skid_q)
  );

  // Counts stalls even during a flush cycle; only reset clears it.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q <= '0;
    end else if (bus.out_valid && !bus.out_ready && (stall_q != {CNT_W{1'b1}})) begin
      stall_q <= stall_q + 1'b1;
    end
  end
endmodule

// File: doc/pipe_reg_elastic.md
PIPE_REG_ELASTIC -- requirements
Module: pipe_reg_elastic

Interface
REQ-001 SHALL have parameter NF, default 5, meaning number of fields carried per stage.
REQ-002 SHALL have parameter W, default 32, meaning width of each field in bits.
REQ-003 SHALL have parameter CNT_W, default 16, meaning width of the stall counter.
REQ-004 SHALL have port clk  input  1  clock; all state updates on posedge clk.
REQ-005 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port in_valid  input  1  upstream stage offers a word.
REQ-007 SHALL have port in_ready  output  1  stage can accept a word this cycle.
REQ-008 SHALL have port in_data  input  NF*W  packed fields; field k = bits [k*W +: W].
REQ-009 SHALL have port flush  input  1  discard all held and incoming words (branch/exception squash).
REQ-010 SHALL have port out_valid  output  1  stage presents a word downstream.
REQ-011 SHALL have port out_ready  input  1  downstream accepts the word this cycle.
REQ-012 SHALL have port out_data  output  NF*W  held word; same field packing as in_data.
REQ-013 SHALL have port stall_cnt  output  CNT_W  count of downstream back-pressure cycles.

Function
REQ-014 SHALL define in-fire = in_valid & in_ready; out-fire = out_valid & out_ready.
REQ-015 SHALL hold a main slot and a skid slot; state EMPTY (none), HALF (main), FULL (main+skid).
REQ-016 SHALL drive in_ready = (state != FULL) and out_valid = (state != EMPTY), both from registered state only.
REQ-017 SHALL drive out_data = main slot; main slot SHALL be all-zero (bubble/nop) whenever state is EMPTY.
REQ-018 EMPTY: in-fire -> HALF, main <= in_data; else stay EMPTY.
REQ-019 HALF: in-fire & out-fire -> HALF, main <= in_data; in-fire only -> FULL, skid <= in_data; out-fire only -> EMPTY, main <= 0; neither -> hold.
REQ-020 FULL: out-fire -> HALF, main <= skid, skid <= 0; else hold; no input accepted.
REQ-021 SHALL give latency of one cycle from in-fire in EMPTY to out_valid = 1 with that word.
REQ-022 SHALL sustain one word per cycle when out_ready is held high; order SHALL be strictly FIFO.
REQ-023 flush = 1 SHALL force next state EMPTY and zero both slots regardless of in-fire/out-fire in that cycle; a simultaneously offered input is dropped.
REQ-024 The cycle after flush SHALL show out_valid = 0, out_data = 0, in_ready = 1.
REQ-025 stall_cnt SHALL increment by 1 on each cycle with out_valid & ~out_ready, saturating at 2^CNT_W-1; flush SHALL NOT clear it.
REQ-026 Held data SHALL never change while out_valid & ~out_ready (except on flush/reset).

Reset
REQ-027 reset SHALL take priority over flush and all handshakes.
REQ-028 On reset: state EMPTY, main = 0, skid = 0, stall_cnt = 0; hence out_valid = 0, in_ready = 1, out_data = 0 next cycle.
REQ-029 Reset mid-transfer SHALL discard any held or offered words without downstream out-fire.

Structure
REQ-030 Shared package pipe_pkg SHALL hold the state enumeration (EMPTY, HALF, FULL) and the bubble constant (all-zero word).
REQ-031 One sub-module pipe_slot (NF*W register with load, clear, hold) SHALL be instantiated twice (main, skid).
REQ-032 No combinational path SHALL exist from in_valid or out_ready to in_ready or out_valid.

Verification
REQ-033 Reset, then in_valid=1, in_data field0=0x24010005, out_ready=1 -> next cycle out_valid=1, out_data field0=0x24010005.
REQ-034 out_ready=0, push 0x11 then 0x22 -> state FULL, in_ready=0, out_data=0x11; raise out_ready -> 0x11 then 0x22 on consecutive cycles.
REQ-035 out_ready=1, push 0x1..0x8 back-to-back -> 0x1..0x8 out on 8 consecutive cycles, in_ready stays 1, stall_cnt=0.
REQ-036 FULL with 0xAA/0xBB, assert flush with in_valid=1, in_data=0xCC -> next cycle out_valid=0, out_data=0, in_ready=1; 0xCC never appears.
REQ-037 CNT_W=4, hold out_valid=1, out_ready=0 for 20 cycles -> stall_cnt reaches 15 and stays; flush leaves 15; reset gives 0.
REQ-038 Assert reset and flush together while HALF -> next cycle EMPTY, all outputs at reset values, stall_cnt=0.
